// File: rtl/soc_pkg.sv
// Shared SoC definitions for the DMA engines and the bus decode.
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [7:0]  DMA_REG_ADDR = 8'h46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN      = 160;

    // Echo RAM E000-FFFF mirrors WRAM C000-DFFF.
    function automatic logic [7:0] echo_fold(
        input logic [7:0] x,
        input logic       en
    );
        return (en && x >= 8'hE0) ? (x & 8'hDF) : x;
    endfunction

endpackage

// File: rtl/oam_dma_ctr.sv
// Byte index counter with clear, enable and terminal-count flag.
module oam_dma_ctr
    import soc_pkg::*;
#(
    parameter int LEN = OAM_LEN
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] idx,
    output logic       tc
);

    logic [7:0] r_idx;

    assign idx = r_idx;
    assign tc  = (r_idx == 8'(LEN - 1));

    // Returns to zero after the terminal count so idx never leaves 0..LEN-1.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_idx <= 8'h00;
        end else if (clr) begin
            r_idx <= 8'h00;
        end else if (en) begin
            r_idx <= tc ? 8'h00 : r_idx + 8'h01;
        end
    end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine behind FF46: copies a source page into OAM, one byte per M-cycle.
module oam_dma
    import soc_pkg::*;
#(
    parameter int         XFER_LEN  = OAM_LEN,
    parameter logic [7:0] REG_ADDR  = DMA_REG_ADDR,
    parameter int         ECHO_FOLD = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        mcyc,
    input  logic        ffxx,
    input  logic [7:0]  a,
    input  logic        soc_wr,
    input  logic        soc_rd,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [15:0] dma_a,
    output logic        dma_rd,
    input  logic [7:0]  dma_din,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_wr,
    output logic        cpu_block
);

    dma_state_t r_state;
    logic [7:0] r_src_hi;
    logic [7:0] r_oam_a;
    logic [7:0] r_oam_d;
    logic       r_oam_wr;

    logic       w_hit;
    logic       w_reg_wr;
    logic       w_xfer;
    logic       w_step;
    logic [7:0] w_idx;
    logic       w_tc;

    assign w_hit    = ffxx && (a == REG_ADDR);
    assign w_reg_wr = w_hit && soc_wr && mcyc;
    assign w_xfer   = (r_state == XFER);
    // A register write on the same M-cycle drops the in-flight byte.
    assign w_step   = w_xfer && mcyc && !w_reg_wr;

    oam_dma_ctr #(
        .LEN (XFER_LEN)
    ) u_ctr (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (w_reg_wr),
        .en      (w_step),
        .idx     (w_idx),
        .tc      (w_tc)
    );

    assign d_out     = r_src_hi;
    assign d_oe      = w_hit && soc_rd;
    assign dma_rd    = w_xfer;
    assign cpu_block = w_xfer;
    assign dma_a     = w_xfer
        ? {echo_fold(r_src_hi, ECHO_FOLD != 0), w_idx}
        : 16'h0000;
    assign oam_a     = r_oam_a;
    assign oam_d     = r_oam_d;
    assign oam_wr    = r_oam_wr;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= IDLE;
            r_src_hi <= 8'h00;
        end else if (w_reg_wr) begin
            r_state  <= SETUP;
            r_src_hi <= d_in;
        end else if (mcyc) begin
            unique case (r_state)
                SETUP:   r_state <= XFER;
                XFER:    r_state <= w_tc ? IDLE : XFER;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_oam_wr <= 1'b0;
            r_oam_a  <= 8'h00;
            r_oam_d  <= 8'h00;
        end else begin
            r_oam_wr <= w_step;
            if (w_step) begin
                r_oam_a <= w_idx;
                r_oam_d <= dma_din;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: copy, readback, echo fold, restart, stall, reset.
module tb_oam_dma;

    logic        clk;
    logic        n_reset;
    logic        mcyc;
    logic        ffxx;
    logic [7:0]  a;
    logic        soc_wr;
    logic        soc_rd;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [15:0] dma_a;
    logic        dma_rd;
    logic [7:0]  dma_din;
    logic [7:0]  oam_a;
    logic [7:0]  oam_d;
    logic        oam_wr;
    logic        cpu_block;

    logic [7:0]  d_out1;
    logic        d_oe1;
    logic [15:0] dma_a1;
    logic        dma_rd1;
    logic [7:0]  dma_din1;
    logic [7:0]  oam_a1;
    logic [7:0]  oam_d1;
    logic        oam_wr1;
    logic        cpu_block1;

    int total = 0;
    int bad   = 0;

    int          wr_cnt;
    int          rd_cnt;
    int          blk_cnt;
    logic [7:0]  seq_a [0:511];
    logic [7:0]  seq_d [0:511];
    logic [15:0] seq_s [0:511];

    assign dma_din  = dma_a[7:0];
    assign dma_din1 = dma_a1[7:0];

    oam_dma u_dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .mcyc      (mcyc),
        .ffxx      (ffxx),
        .a         (a),
        .soc_wr    (soc_wr),
        .soc_rd    (soc_rd),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .dma_a     (dma_a),
        .dma_rd    (dma_rd),
        .dma_din   (dma_din),
        .oam_a     (oam_a),
        .oam_d     (oam_d),
        .oam_wr    (oam_wr),
        .cpu_block (cpu_block)
    );

    oam_dma #(.ECHO_FOLD(0)) u_nofold (
        .clk       (clk),
        .n_reset   (n_reset),
        .mcyc      (mcyc),
        .ffxx      (ffxx),
        .a         (a),
        .soc_wr    (soc_wr),
        .soc_rd    (soc_rd),
        .d_in      (d_in),
        .d_out     (d_out1),
        .d_oe      (d_oe1),
        .dma_a     (dma_a1),
        .dma_rd    (dma_rd1),
        .dma_din   (dma_din1),
        .oam_a     (oam_a1),
        .oam_d     (oam_d1),
        .oam_wr    (oam_wr1),
        .cpu_block (cpu_block1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs move 1ns after posedge, so negedge sees the upcoming edge's view.
    always @(negedge clk) begin
        if (oam_wr) begin
            if (wr_cnt < 512) begin
                seq_a[wr_cnt] = oam_a;
                seq_d[wr_cnt] = oam_d;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (mcyc && dma_rd) begin
            if (rd_cnt < 512) seq_s[rd_cnt] = dma_a;
            rd_cnt = rd_cnt + 1;
        end
        if (mcyc && cpu_block) blk_cnt = blk_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk1(input logic m);
        mcyc = m;
        @(posedge clk);
        #1;
        mcyc = 1'b0;
    endtask

    task automatic mc();
        repeat (3) clk1(1'b0);
        clk1(1'b1);
    endtask

    task automatic wr_reg(input logic [7:0] v);
        ffxx   = 1'b1;
        a      = 8'h46;
        d_in   = v;
        soc_wr = 1'b1;
        mc();
        soc_wr = 1'b0;
        ffxx   = 1'b0;
        a      = 8'h00;
    endtask

    task automatic clr_log();
        wr_cnt  = 0;
        rd_cnt  = 0;
        blk_cnt = 0;
    endtask

    task automatic run_out();
        for (int n = 0; n < 200 && cpu_block; n++) mc();
        clk1(1'b0);
        chk("xfer_ends", {15'h0, cpu_block}, 16'h0000);
    endtask

    int e;
    int snap;

    initial begin
        n_reset = 1'b0;
        mcyc    = 1'b0;
        ffxx    = 1'b0;
        a       = 8'h00;
        soc_wr  = 1'b0;
        soc_rd  = 1'b0;
        d_in    = 8'h00;
        clr_log();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oam_wr", {15'h0, oam_wr}, 16'h0000);
        chk("rst_block", {15'h0, cpu_block}, 16'h0000);
        chk("rst_dma_rd", {15'h0, dma_rd}, 16'h0000);
        chk("rst_dma_a", dma_a, 16'h0000);
        chk("rst_oam_a", {8'h0, oam_a}, 16'h0000);
        chk("rst_oam_d", {8'h0, oam_d}, 16'h0000);
        chk("rst_d_out", {8'h0, d_out}, 16'h0000);
        n_reset = 1'b1;
        mc();

        // write strobe with no mcyc is ignored
        ffxx = 1'b1; a = 8'h46; d_in = 8'hAA; soc_wr = 1'b1;
        repeat (3) clk1(1'b0);
        soc_wr = 1'b0; ffxx = 1'b0; a = 8'h00;
        chk("nomcyc_d_out", {8'h0, d_out}, 16'h0000);
        chk("nomcyc_state", {15'h0, cpu_block}, 16'h0000);
        mc();
        chk("nomcyc_idle", {15'h0, dma_rd}, 16'h0000);

        // basic copy from C100
        clr_log();
        wr_reg(8'hC1);
        chk("setup_block", {15'h0, cpu_block}, 16'h0000);
        chk("setup_dma_rd", {15'h0, dma_rd}, 16'h0000);
        chk("setup_d_out", {8'h0, d_out}, 16'h00C1);
        mc();
        chk("xfer_block", {15'h0, cpu_block}, 16'h0001);
        chk("xfer_dma_rd", {15'h0, dma_rd}, 16'h0001);
        chk("xfer_dma_a0", dma_a, 16'hC100);
        repeat (3) clk1(1'b0);
        chk("no_early_wr", wr_cnt[15:0], 16'h0000);
        clk1(1'b1);
        chk("first_wr", {15'h0, oam_wr}, 16'h0001);
        chk("first_oam_a", {8'h0, oam_a}, 16'h0000);
        chk("dma_a1", dma_a, 16'hC101);
        clk1(1'b0);
        chk("wr_one_clk", {15'h0, oam_wr}, 16'h0000);
        clk1(1'b0);
        clk1(1'b0);
        clk1(1'b1);
        repeat (78) mc();
        chk("mid_dma_a", dma_a, 16'hC150);
        ffxx = 1'b1; a = 8'h46; soc_rd = 1'b1;
        #1;
        chk("rb_d_out", {8'h0, d_out}, 16'h00C1);
        chk("rb_d_oe", {15'h0, d_oe}, 16'h0001);
        chk("rb_block", {15'h0, cpu_block}, 16'h0001);
        a = 8'h47;
        #1;
        chk("rb_other_oe", {15'h0, d_oe}, 16'h0000);
        soc_rd = 1'b0; ffxx = 1'b0; a = 8'h00;
        run_out();
        chk("basic_wr_cnt", wr_cnt[15:0], 16'd160);
        chk("basic_blk_cnt", blk_cnt[15:0], 16'd160);
        chk("basic_rd_cnt", rd_cnt[15:0], 16'd160);
        e = 0;
        for (int i = 0; i < 160; i++) begin
            if (seq_a[i] !== 8'(i)) e++;
            if (seq_d[i] !== 8'(i)) e++;
            if (seq_s[i] !== 16'hC100 + 16'(i)) e++;
        end
        chk("basic_seq_errs", e[15:0], 16'h0000);
        chk("idle_dma_a", dma_a, 16'h0000);

        // echo fold, with and without folding, and the DF boundary
        wr_reg(8'hE3);
        chk("echo_d_out", {8'h0, d_out}, 16'h00E3);
        mc();
        chk("echo_fold", dma_a, 16'hC300);
        chk("echo_nofold", dma_a1, 16'hE300);
        wr_reg(8'hDF);
        mc();
        chk("df_nofold", dma_a, 16'hDF00);

        // restart mid-transfer
        wr_reg(8'h80);
        clr_log();
        mc();
        repeat (50) mc();
        chk("rs_dma_a50", dma_a, 16'h8032);
        wr_reg(8'h90);
        chk("rs_setup_blk", {15'h0, cpu_block}, 16'h0000);
        chk("rs_no_wr50", wr_cnt[15:0], 16'd50);
        chk("rs_d_out", {8'h0, d_out}, 16'h0090);
        mc();
        chk("rs_dma_a0", dma_a, 16'h9000);
        run_out();
        chk("rs_wr_cnt", wr_cnt[15:0], 16'd210);
        chk("rs_rd_cnt", rd_cnt[15:0], 16'd211);
        e = 0;
        for (int i = 0; i < 50; i++) begin
            if (seq_a[i] !== 8'(i)) e++;
            if (seq_s[i] !== 16'h8000 + 16'(i)) e++;
        end
        if (seq_s[50] !== 16'h8032) e++;
        for (int i = 0; i < 160; i++) begin
            if (seq_a[50 + i] !== 8'(i)) e++;
            if (seq_d[50 + i] !== 8'(i)) e++;
            if (seq_s[51 + i] !== 16'h9000 + 16'(i)) e++;
        end
        chk("rs_seq_errs", e[15:0], 16'h0000);

        // stall: mcyc held low for 10 clks
        wr_reg(8'hC1);
        mc();
        repeat (10) mc();
        clk1(1'b0);
        snap = wr_cnt;
        chk("st_dma_a", dma_a, 16'hC10A);
        repeat (9) clk1(1'b0);
        chk("st_no_wr", 16'(wr_cnt - snap), 16'h0000);
        chk("st_dma_a_frz", dma_a, 16'hC10A);
        chk("st_block", {15'h0, cpu_block}, 16'h0001);
        chk("st_oam_wr", {15'h0, oam_wr}, 16'h0000);
        mc();
        chk("st_resume_wr", {15'h0, oam_wr}, 16'h0001);
        chk("st_resume_a", {8'h0, oam_a}, 16'h000A);
        chk("st_resume_d", {8'h0, oam_d}, 16'h000A);

        // async reset at idx 20
        repeat (9) mc();
        chk("rr_dma_a", dma_a, 16'hC114);
        #2;
        n_reset = 1'b0;
        #1;
        chk("rr_block", {15'h0, cpu_block}, 16'h0000);
        chk("rr_dma_rd", {15'h0, dma_rd}, 16'h0000);
        chk("rr_dma_a0", dma_a, 16'h0000);
        chk("rr_oam_wr", {15'h0, oam_wr}, 16'h0000);
        chk("rr_oam_a", {8'h0, oam_a}, 16'h0000);
        chk("rr_oam_d", {8'h0, oam_d}, 16'h0000);
        chk("rr_d_out", {8'h0, d_out}, 16'h0000);
        mc();
        n_reset = 1'b1;
        snap = wr_cnt;
        repeat (5) mc();
        chk("rr_no_wr", 16'(wr_cnt - snap), 16'h0000);
        chk("rr_idle", {15'h0, cpu_block}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine behind register FF46.
- A CPU write to FF46 copies XFER_LEN bytes from {src_hi, 8'h00} into OAM (FE00+i), one byte per M-cycle.
- While the copy runs it asserts cpu_block. The SoC arbiter then lets the CPU reach only the FFxx window (HRAM, I/O). This keeps HRAM usable during DMA.
- It sits between the SoC bus decode (same ffxx/a/soc_wr qualifiers the HRAM block uses) and the OAM write port.

Parameters:
- XFER_LEN, 160, number of bytes copied per transfer (index 0..XFER_LEN-1).
- REG_ADDR, 8'h46, low address byte of the control register within FFxx.
- ECHO_FOLD, 1, when 1, src_hi values E0..FF are folded to src_hi & 8'hDF (echo RAM to WRAM).

Ports:
- clk, input, 1, system clock.
- n_reset, input, 1, asynchronous active-low reset.
- mcyc, input, 1, one-clk strobe marking the end of each M-cycle; all state advance is qualified by it.
- ffxx, input, 1, address high byte == FF.
- a, input, 8, CPU address low byte.
- soc_wr, input, 1, CPU write strobe.
- soc_rd, input, 1, CPU read strobe.
- d_in, input, 8, CPU write data.
- d_out, output, 8, FF46 readback data.
- d_oe, output, 1, drive enable for d_out (ffxx & a==REG_ADDR & soc_rd).
- dma_a, output, 16, source address on the DMA bus.
- dma_rd, output, 1, DMA source read request.
- dma_din, input, 8, source data returned by the bus (valid at mcyc).
- oam_a, output, 8, OAM byte index.
- oam_d, output, 8, OAM write data.
- oam_wr, output, 1, OAM write pulse, one clk wide.
- cpu_block, output, 1, CPU restricted to FFxx.

Behaviour:
- Reset (async, n_reset=0):
  - state=IDLE, src_hi=8'h00, idx=0.
  - dma_rd=0, oam_wr=0, cpu_block=0, oam_a=0, oam_d=0, dma_a=16'h0000, d_out=8'h00.
- Register write:
  - Trigger: ffxx & a==REG_ADDR & soc_wr & mcyc.
  - src_hi<=d_in, idx<=0, state<=SETUP. This applies from any state (restart).
- Register read: d_out = src_hi at all times, including mid-transfer.
- States:
  - IDLE: no outputs active.
  - SETUP: lasts exactly one M-cycle.
    - cpu_block=0, dma_rd=0.
    - On the next mcyc: state<=XFER.
  - XFER:
    - cpu_block=1, dma_rd=1, dma_a={fold(src_hi), idx}.
    - On each mcyc: oam_d<=dma_din, oam_a<=idx, oam_wr<=1 for the following clk only, idx<=idx+1.
    - When idx==XFER_LEN-1 at mcyc: last write issued, state<=IDLE, cpu_block drops on the same edge.
- Latency:
  - The register write's mcyc starts SETUP.
  - First oam_wr occurs 1 clk after the 2nd mcyc following the write.
  - Total XFER_LEN+1 M-cycles from write to IDLE.
- idx is 8 bits and never exceeds XFER_LEN-1; no wrap inside a transfer.
- Restart mid-XFER:
  - The in-flight byte at that mcyc is NOT written (the register write has priority).
  - SETUP re-entered, cpu_block=0 during SETUP, then a full new transfer from idx 0.
- A write to FF46 during SETUP reloads src_hi and restarts SETUP.
- FF46 access is never blocked by cpu_block (it lies in FFxx).
- soc_wr without mcyc has no effect.
- mcyc gaps (CPU stalled) freeze all state.
- Reset mid-transfer: immediate IDLE; no further oam_wr.
- fold(x) = (ECHO_FOLD && x>=8'hE0) ? x & 8'hDF : x.

Decomposition:
- Shared package (soc_pkg): state enum {IDLE, SETUP, XFER}, DMA_REG_ADDR=8'h46, OAM_BASE=16'hFE00, OAM_LEN=160.
- One sub-module, oam_dma_ctr:
  - 8-bit index counter with clear, enable and terminal-count flag (tc when idx==XFER_LEN-1).
  - Reused by the future VRAM/HDMA engine.
- Register decode and FSM stay in oam_dma.

Test Plan:
- Basic copy:
  - Stimulus: write 8'hC1 to FF46; source returns dma_din=low byte of dma_a.
  - Response: 160 oam_wr pulses, oam_a 0..159, oam_d==oam_a, dma_a C100..C19F.
  - cpu_block high for exactly 160 M-cycles, low during SETUP.
- Readback: read FF46 mid-transfer -> d_out=8'hC1, d_oe=1; cpu_block unaffected; transfer continues.
- Echo fold: write 8'hE3 -> dma_a starts 16'hC300; with ECHO_FOLD=0 -> 16'hE300.
- Restart:
  - Stimulus: write 8'h80, then at idx=50 write 8'h90.
  - Response: no write for idx 50 from the 80xx source; one SETUP M-cycle with cpu_block=0; then oam_a 0..159 from 9000..909F.
- Reset mid-XFER: pull n_reset low at idx=20 without a clk edge -> outputs at reset values immediately; no further oam_wr after release.
- Stall: hold mcyc low for 10 clks during XFER -> idx, dma_a and cpu_block frozen, no oam_wr; resumes at the same idx.
